// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : serial_pkg
//  Brief   : Shared types and defaults for the serializer / detector path.
//  Revision: 1.0
// ============================================================================
package serial_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    localparam int SER_DATA_W = 8;

endpackage : serial_pkg
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module  : bit_serializer
//  Brief   : Valid/ready parallel-in, one-bit-per-clock serial-out stage.
//  Revision: 1.0
// ============================================================================
module bit_serializer
    import serial_pkg::*;
#(
    parameter int DATA_W    = SER_DATA_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              string_o,
    output logic              string_vld_o,
    output logic              last_o,
    output logic              busy_o
);

    localparam int               c_CNT_W = $clog2(DATA_W);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_W - 1);

    ser_state_e          r_state;
    logic [DATA_W-1:0]   r_shreg;
    logic [c_CNT_W-1:0]  r_bit_cnt;

    logic                w_busy;
    logic                w_at_last;
    logic                w_ready;
    logic                w_accept;
    logic                w_out_bit;
    logic [DATA_W-1:0]   w_shifted;

    assign w_busy    = (r_state == SHIFT);
    assign w_at_last = w_busy && (r_bit_cnt == c_LAST);
    // Accepting on the last-bit cycle lets consecutive words abut with no gap.
    assign w_ready   = !rst_i && (!w_busy || w_at_last);
    assign w_accept  = valid_i && w_ready;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_out_bit = r_shreg[DATA_W-1];
            assign w_shifted = {r_shreg[DATA_W-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_out_bit = r_shreg[0];
            assign w_shifted = {1'b0, r_shreg[DATA_W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shreg   <= data_i;
                        r_bit_cnt <= '0;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_accept) begin
                        r_shreg   <= data_i;
                        r_bit_cnt <= '0;
                    end else if (w_at_last) begin
                        r_shreg   <= w_shifted;
                        r_bit_cnt <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_shreg   <= w_shifted;
                        r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready_o      = w_ready;
    assign string_o     = w_busy && w_out_bit;
    assign string_vld_o = w_busy;
    assign last_o       = w_at_last;
    assign busy_o       = w_busy;

endmodule : bit_serializer
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_bit_serializer
//  Brief   : Checks MSB-first and LSB-first serializers against a bit queue.
//  Revision: 1.0
// ============================================================================
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         valid = 1'b0;
    logic [W-1:0] data  = '0;

    logic m_ready, m_str, m_vld, m_last, m_busy;
    logic l_ready, l_str, l_vld, l_last, l_busy;

    int total = 0;
    int bad   = 0;

    // Expected serial streams: every accepted word appends its bits in order.
    bit qm[$];
    bit ql[$];

    bit_serializer #(.DATA_W(W), .MSB_FIRST(1'b1)) u_msb (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid),
        .ready_o(m_ready), .string_o(m_str), .string_vld_o(m_vld),
        .last_o(m_last), .busy_o(m_busy)
    );

    bit_serializer #(.DATA_W(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid),
        .ready_o(l_ready), .string_o(l_str), .string_vld_o(l_vld),
        .last_o(l_last), .busy_o(l_busy)
    );

    always #5 clk = ~clk;

    function automatic bit exp_ready();
        return !rst && (qm.size() <= 1);
    endfunction

    function automatic bit exp_vld();
        return qm.size() > 0;
    endfunction

    function automatic bit exp_last();
        return qm.size() == 1;
    endfunction

    function automatic bit exp_str_m();
        return (qm.size() > 0) ? qm[0] : 1'b0;
    endfunction

    function automatic bit exp_str_l();
        return (ql.size() > 0) ? ql[0] : 1'b0;
    endfunction

    task automatic tick();
        bit           acc;
        logic [W-1:0] word;
        acc  = valid && exp_ready();
        word = data;
        @(posedge clk);
        if (rst) begin
            qm.delete();
            ql.delete();
        end else begin
            if (qm.size() > 0) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (acc) begin
                for (int i = 0; i < W; i++) begin
                    qm.push_back(word[W-1-i]);
                    ql.push_back(word[i]);
                end
            end
        end
        #1;
    endtask

    task automatic drain();
        valid = 1'b0;
        for (int i = 0; i < 2*W + 2 && qm.size() > 0; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        #1;
        total++; if (m_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", m_ready); end
        total++; if (m_vld !== 1'b0 || l_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b/%b exp=0", m_vld, l_vld); end
        total++; if (m_busy !== 1'b0 || m_last !== 1'b0 || m_str !== 1'b0) begin bad++; $display("FAIL reset_outs busy=%b last=%b str=%b exp=0", m_busy, m_last, m_str); end
        rst = 1'b0;
        #1;
        total++; if (m_ready !== 1'b1 || l_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b/%b exp=1", m_ready, l_ready); end
        total++; if (m_busy !== 1'b0) begin bad++; $display("FAIL release_busy got=%b exp=0", m_busy); end
    endtask

    task automatic test_single(input logic [W-1:0] word, input string tag);
        drain();
        data  = word;
        valid = 1'b1;
        for (int c = 0; c <= W + 1; c++) begin
            #1;
            total++; if (m_str !== exp_str_m() || m_vld !== exp_vld()) begin bad++; $display("FAIL %s_msb cyc=%0d str=%b vld=%b exp str=%b vld=%b", tag, c, m_str, m_vld, exp_str_m(), exp_vld()); end
            total++; if (l_str !== exp_str_l() || l_vld !== exp_vld()) begin bad++; $display("FAIL %s_lsb cyc=%0d str=%b vld=%b exp str=%b vld=%b", tag, c, l_str, l_vld, exp_str_l(), exp_vld()); end
            total++; if (m_last !== exp_last() || m_ready !== exp_ready()) begin bad++; $display("FAIL %s_ctl cyc=%0d last=%b ready=%b exp last=%b ready=%b", tag, c, m_last, m_ready, exp_last(), exp_ready()); end
            tick();
            valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int n_acc;
        drain();
        n_acc = 0;
        data  = 8'h0A;
        valid = 1'b1;
        for (int c = 0; c <= 2*W + 1; c++) begin
            #1;
            total++; if (m_str !== exp_str_m() || m_vld !== exp_vld()) begin bad++; $display("FAIL b2b_stream cyc=%0d str=%b vld=%b exp str=%b vld=%b", c, m_str, m_vld, exp_str_m(), exp_vld()); end
            total++; if (m_ready !== exp_ready() || m_busy !== exp_vld() || l_busy !== exp_vld()) begin bad++; $display("FAIL b2b_ctl cyc=%0d ready=%b busy=%b exp ready=%b busy=%b", c, m_ready, m_busy, exp_ready(), exp_vld()); end
            if (valid && exp_ready()) n_acc++;
            tick();
            if (n_acc == 1) data = 8'hA0;
            if (n_acc == 2) valid = 1'b0;
        end
        total++; if (n_acc != 2) begin bad++; $display("FAIL b2b_accepts got=%0d exp=2", n_acc); end
    endtask

    task automatic test_ignore_busy();
        drain();
        data  = 8'($urandom);
        valid = 1'b1;
        tick();
        for (int c = 0; c < 4*W; c++) begin
            valid = exp_ready() ? 1'b0 : 1'($urandom);
            data  = 8'($urandom);
            #1;
            total++; if (m_str !== exp_str_m() || l_str !== exp_str_l() || m_vld !== exp_vld()) begin bad++; $display("FAIL ignore_busy cyc=%0d str=%b/%b vld=%b exp %b/%b vld=%b", c, m_str, l_str, m_vld, exp_str_m(), exp_str_l(), exp_vld()); end
            total++; if (m_ready !== exp_ready() || m_last !== exp_last()) begin bad++; $display("FAIL ignore_ctl cyc=%0d ready=%b last=%b exp ready=%b last=%b", c, m_ready, m_last, exp_ready(), exp_last()); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        drain();
        data  = 8'hFF;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        rst = 1'b1;
        #1;
        total++; if (m_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b exp=0", m_ready); end
        tick();
        rst = 1'b0;
        #1;
        total++; if (m_vld !== 1'b0 || l_vld !== 1'b0 || m_busy !== 1'b0) begin bad++; $display("FAIL midrst_vld got=%b/%b busy=%b exp=0", m_vld, l_vld, m_busy); end
        test_single(8'h81, "after_rst");
    endtask

    task automatic test_random();
        drain();
        for (int c = 0; c < 400; c++) begin
            valid = ($urandom_range(0, 3) != 0);
            data  = 8'($urandom);
            rst   = ($urandom_range(0, 60) == 0);
            #1;
            total++; if (m_str !== exp_str_m() || l_str !== exp_str_l() || m_vld !== exp_vld() || l_vld !== exp_vld()) begin bad++; $display("FAIL rand_stream cyc=%0d str=%b/%b vld=%b/%b exp %b/%b vld=%b", c, m_str, l_str, m_vld, l_vld, exp_str_m(), exp_str_l(), exp_vld()); end
            total++; if (m_ready !== exp_ready() || m_last !== exp_last() || l_last !== exp_last() || m_busy !== exp_vld()) begin bad++; $display("FAIL rand_ctl cyc=%0d ready=%b last=%b/%b busy=%b exp ready=%b last=%b", c, m_ready, m_last, l_last, m_busy, exp_ready(), exp_last()); end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single(8'hA5, "single_a5");
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_single(8'h01, "order_01");
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bit_serializer
`default_nettype wire
